// File: rtl/sel_seq_ctrl_pkg.sv
// Shared phase codes, FSM state type and one-hot key helpers for the cell-selection sequencer.
package sel_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ROW  = 2'b01;
  localparam logic [1:0] ST_COL  = 2'b10;
  localparam logic [1:0] ST_CONF = 2'b11;

  // Encodings equal the phase codes so st can be driven straight from the state register.
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ROW  = ST_ROW,
    S_COL  = ST_COL,
    S_CONF = ST_CONF
  } state_t;

  function automatic logic is_onehot(input logic [3:0] k);
    case (k)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: is_onehot = 1'b1;
      default:                            is_onehot = 1'b0;
    endcase
  endfunction

  // k[3] is key_one (index 0) down to k[0] is key_four (index 3).
  function automatic logic [1:0] onehot_idx(input logic [3:0] k);
    case (k)
      4'b1000: onehot_idx = 2'd0;
      4'b0100: onehot_idx = 2'd1;
      4'b0010: onehot_idx = 2'd2;
      4'b0001: onehot_idx = 2'd3;
      default: onehot_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sel_seq_ctrl_if.sv
// Control/status bundle between the sequencer (slave) and its user (master).
interface sel_seq_ctrl_if;
  logic        start;
  logic        cancel;
  logic        clr_occ;
  logic        key_one;
  logic        key_two;
  logic        key_three;
  logic        key_four;
  logic [1:0]  st;
  logic        busy;
  logic [1:0]  cell_row;
  logic [1:0]  cell_col;
  logic        cell_valid;
  logic        err;
  logic [15:0] occ;

  modport master (
    output start, cancel, clr_occ, key_one, key_two, key_three, key_four,
    input  st, busy, cell_row, cell_col, cell_valid, err, occ
  );

  modport slave (
    input  start, cancel, clr_occ, key_one, key_two, key_three, key_four,
    output st, busy, cell_row, cell_col, cell_valid, err, occ
  );
endinterface

// File: rtl/sel_seq_ctrl_key_evt.sv
// Key press detector: fires evt for one cycle when exactly one key goes down from all-released.
module key_evt
  import sel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] k,
  output logic       evt,
  output logic [1:0] idx
);

  logic [3:0] k_q;

  always_ff @(posedge clk) begin
    if (rst) k_q <= 4'b0;
    else     k_q <= k;
  end

  // Requiring k_q == 0 rejects held keys and roll-overs from a multi-key pattern.
  assign evt = is_onehot(k) && (k_q == 4'b0);
  assign idx = onehot_idx(k);

endmodule

// File: rtl/sel_seq_ctrl.sv
// Row-then-column cell selection sequencer with occupancy tracking, abort and inactivity timeout.
// Build option SEL_OCC_CHECK_EN: reject selection of an already-occupied cell.
module sel_seq_ctrl
  import sel_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TMR_W       = 26
) (
  input  logic          clk,
  input  logic          rst,
  sel_seq_ctrl_if.slave bus
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state, nxt;
  logic             evt;
  logic [1:0]       idx;
  logic [TMR_W-1:0] timer;
  logic [1:0]       row_r, col_r;
  logic [1:0]       cell_row_r, cell_col_r;
  logic             cell_valid_r, err_r;
  logic [15:0]      occ_r;
  logic             tmo, commit, reject, occ_hit;

  key_evt u_key_evt (
    .clk (clk),
    .rst (rst),
    .k   ({bus.key_one, bus.key_two, bus.key_three, bus.key_four}),
    .evt (evt),
    .idx (idx)
  );

`ifdef SEL_OCC_CHECK_EN
  assign occ_hit = occ_r[{row_r, col_r}];
`else
  assign occ_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Priority: cancel > timeout > key event.
  always_comb begin
    nxt    = state;
    tmo    = 1'b0;
    commit = 1'b0;
    reject = 1'b0;
    case (state)
      S_IDLE: if (bus.start) nxt = S_ROW;
      S_ROW: begin
        if (bus.cancel)              nxt = S_IDLE;
        else if (timer == TMO_LAST) begin nxt = S_IDLE; tmo = 1'b1; end
        else if (evt)                nxt = S_COL;
      end
      S_COL: begin
        if (bus.cancel)              nxt = S_IDLE;
        else if (timer == TMO_LAST) begin nxt = S_IDLE; tmo = 1'b1; end
        else if (evt)                nxt = S_CONF;
      end
      S_CONF: begin
        if (bus.cancel)   nxt = S_IDLE;
        else if (occ_hit) begin nxt = S_ROW;  reject = 1'b1; end
        else              begin nxt = S_IDLE; commit = 1'b1; end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.st         = state;
    bus.busy       = (state != S_IDLE);
    bus.cell_row   = cell_row_r;
    bus.cell_col   = cell_col_r;
    bus.cell_valid = cell_valid_r;
    bus.err        = err_r;
    bus.occ        = occ_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer        <= '0;
      row_r        <= 2'd0;
      col_r        <= 2'd0;
      cell_row_r   <= 2'd0;
      cell_col_r   <= 2'd0;
      cell_valid_r <= 1'b0;
      err_r        <= 1'b0;
      occ_r        <= 16'h0;
    end else begin
      cell_valid_r <= commit;
      err_r        <= tmo | reject;
      // Any transition (event, timeout, cancel, reject) restarts the inactivity count.
      if ((state == S_ROW || state == S_COL) && nxt == state) timer <= timer + TMR_W'(1);
      else                                                    timer <= '0;
      if (state == S_ROW && nxt == S_COL)  row_r <= idx;
      if (state == S_COL && nxt == S_CONF) col_r <= idx;
      if (commit) begin
        cell_row_r <= row_r;
        cell_col_r <= col_r;
      end
      if (bus.clr_occ)  occ_r                 <= 16'h0;
      else if (commit)  occ_r[{row_r, col_r}] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sel_seq_ctrl.sv
// Directed self-checking bench for sel_seq_ctrl (timeout shortened to 20 cycles).
module tb_sel_seq_ctrl;

  logic clk;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  logic [1:0]  exp_row, exp_col;
  logic [15:0] exp_occ;

  sel_seq_ctrl_if bus ();

  sel_seq_ctrl #(.TIMEOUT_CYC(20), .TMR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic keys(input logic [3:0] k);
    {bus.key_one, bus.key_two, bus.key_three, bus.key_four} = k;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full selection from IDLE; returns sampled in the cycle after CONF resolves.
  task automatic do_select(input logic [3:0] rk, input logic [3:0] ck);
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    keys(rk); tick();
    keys(4'b0); tick();
    keys(ck); tick();
    keys(4'b0); tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.clr_occ = 1'b0;
    keys(4'b0);
    tick(); tick();
    check("rst_st", bus.st, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cell", {bus.cell_row, bus.cell_col}, 4'h0);
    check("rst_pulses", {bus.cell_valid, bus.err}, 2'b00);
    check("rst_occ", bus.occ, 16'h0);
    rst = 1'b0;

    // Basic selection (2,1)
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    check("t1_row_st", bus.st, 2'b01);
    check("t1_busy", bus.busy, 1'b1);
    keys(4'b0010); tick();
    check("t1_col_st", bus.st, 2'b10);
    keys(4'b0); tick();
    check("t1_col_hold", bus.st, 2'b10);
    keys(4'b0100); tick();
    check("t1_conf_st", bus.st, 2'b11);
    check("t1_conf_valid", bus.cell_valid, 1'b0);
    keys(4'b0); tick();
    check("t1_idle_st", bus.st, 2'b00);
    check("t1_valid", bus.cell_valid, 1'b1);
    check("t1_cell", {bus.cell_row, bus.cell_col}, {2'd2, 2'd1});
    check("t1_occ", bus.occ, 16'h0200);
    tick();
    check("t1_valid_drop", bus.cell_valid, 1'b0);

    // Multi-key and held key give no event
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    keys(4'b1100); tick();
    check("t2_multi", bus.st, 2'b01);
    keys(4'b1000); tick();
    check("t2_roll", bus.st, 2'b01);
    tick();
    check("t2_held", bus.st, 2'b01);
    keys(4'b0); tick();
    check("t2_release", bus.st, 2'b01);
    keys(4'b0001); tick();
    check("t2_col", bus.st, 2'b10);
    keys(4'b0); tick();
    keys(4'b1000); tick();
    keys(4'b0); tick();
    check("t2_cell", {bus.cell_row, bus.cell_col}, {2'd3, 2'd0});
    check("t2_occ", bus.occ, 16'h1200);
    check("t2_valid", bus.cell_valid, 1'b1);

    // Re-select (2,1)
    do_select(4'b0010, 4'b0100);
`ifdef SEL_OCC_CHECK_EN
    check("t3_st", bus.st, 2'b01);
    check("t3_pulses", {bus.cell_valid, bus.err}, 2'b01);
    check("t3_cell", {bus.cell_row, bus.cell_col}, {2'd3, 2'd0});
    exp_row = 2'd3; exp_col = 2'd0;
    bus.cancel = 1'b1; tick();
    bus.cancel = 1'b0;
    check("t3_cancel_st", bus.st, 2'b00);
    check("t3_cancel_err", bus.err, 1'b0);
`else
    check("t3_st", bus.st, 2'b00);
    check("t3_pulses", {bus.cell_valid, bus.err}, 2'b10);
    check("t3_cell", {bus.cell_row, bus.cell_col}, {2'd2, 2'd1});
    exp_row = 2'd2; exp_col = 2'd1;
`endif
    check("t3_occ", bus.occ, 16'h1200);
    bus.cancel = 1'b1; tick();
    bus.cancel = 1'b0;
    check("idle_cancel", {bus.st, bus.busy}, 3'b000);

    // Timeout after 20 idle cycles in ROW
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check("t4_pre_st", bus.st, 2'b01);
    check("t4_pre_err", bus.err, 1'b0);
    tick();
    check("t4_st", bus.st, 2'b00);
    check("t4_err", bus.err, 1'b1);
    check("t4_valid", bus.cell_valid, 1'b0);
    check("t4_cell", {bus.cell_row, bus.cell_col}, {exp_row, exp_col});
    tick();
    check("t4_err_drop", bus.err, 1'b0);

    // Cancel coincident with column event
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    keys(4'b0001); tick();
    keys(4'b0); tick();
    keys(4'b0100); bus.cancel = 1'b1; tick();
    check("t5_cancel_st", bus.st, 2'b00);
    check("t5_cancel_pulses", {bus.cell_valid, bus.err}, 2'b00);
    keys(4'b0); bus.cancel = 1'b0; tick();
    check("t5_after_pulses", {bus.cell_valid, bus.err}, 2'b00);
    check("t5_after_cell", {bus.cell_row, bus.cell_col}, {exp_row, exp_col});

    // clr_occ coincident with accept of (1,2)
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    keys(4'b0100); tick();
    keys(4'b0); tick();
    keys(4'b0010); tick();
    keys(4'b0); bus.clr_occ = 1'b1; tick();
    bus.clr_occ = 1'b0;
    check("t5_clr_valid", bus.cell_valid, 1'b1);
    check("t5_clr_occ", bus.occ, 16'h0);
    check("t5_clr_cell", {bus.cell_row, bus.cell_col}, {2'd1, 2'd2});

    // Commit (3,3) then reset while in COL
    do_select(4'b0001, 4'b0001);
    exp_occ = 16'h8000;
    check("t6_occ", bus.occ, exp_occ);
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    keys(4'b0010); tick();
    keys(4'b0);
    check("t6_col", bus.st, 2'b10);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("t6_rst_st", {bus.st, bus.busy}, 3'b000);
    check("t6_rst_cell", {bus.cell_row, bus.cell_col}, 4'h0);
    check("t6_rst_pulses", {bus.cell_valid, bus.err}, 2'b00);
    check("t6_rst_occ", bus.occ, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
